// File: rtl/dual_issue_queue.sv
// Instruction queue feeding two decode slots: slot 1 (any class) and slot 2 (ALU only).
// Define ISSUE_QUEUE_BYPASS_EN to steer fetched lanes straight into decode when the queue is empty.
module dual_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               fetch_valid,
    input  logic [31:0]              fetch_instr0,
    input  logic [31:0]              fetch_instr1,
    input  logic [31:0]              fetch_pc0,
    input  logic [31:0]              fetch_pc1,
    output logic                     fetch_ready,
    input  logic                     stall_d,
    input  logic                     flush_d,
    output logic [31:0]              InstrD,
    output logic [31:0]              PCD,
    output logic                     validD,
    output logic [31:0]              InstrD_2,
    output logic [31:0]              PCD_2,
    output logic                     validD_2,
    output logic                     Order_Change_D,
    output logic [4:0]               rdd,
    output logic [4:0]               rdd_2,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    function automatic logic is_alu(input logic [31:0] instr);
        case (instr[6:0])
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    logic fetch_go;
    logic deq_en;
    logic bypass;

    assign fetch_ready = (count <= CW'(DEPTH - 2));
    assign fetch_go    = fetch_ready && fetch_valid[0];
    assign deq_en      = !stall_d && !flush_d;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign bypass = deq_en && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // Steering candidates: A is always the older of the two.
    logic [31:0] a_instr, a_pc, b_instr, b_pc;
    logic        a_valid, b_valid;

    always_comb begin
        if (bypass) begin
            a_instr = fetch_instr0;
            a_pc    = fetch_pc0;
            a_valid = fetch_go;
            b_instr = fetch_instr1;
            b_pc    = fetch_pc1;
            b_valid = fetch_go && fetch_valid[1];
        end else begin
            a_instr = mem_instr[rd_ptr];
            a_pc    = mem_pc[rd_ptr];
            a_valid = (count != '0);
            b_instr = mem_instr[rd_ptr + PW'(1)];
            b_pc    = mem_pc[rd_ptr + PW'(1)];
            b_valid = (count >= CW'(2));
        end
    end

    logic [31:0] s1_instr, s1_pc, s2_instr, s2_pc;
    logic        s1_valid, s2_valid, s_order;
    logic [1:0]  n_take;

    always_comb begin
        s1_instr = NOP;
        s1_pc    = '0;
        s1_valid = 1'b0;
        s2_instr = NOP;
        s2_pc    = '0;
        s2_valid = 1'b0;
        s_order  = 1'b0;
        n_take   = 2'd0;
        if (a_valid && b_valid) begin
            if (is_alu(b_instr)) begin
                s1_instr = a_instr;  s1_pc = a_pc;  s1_valid = 1'b1;
                s2_instr = b_instr;  s2_pc = b_pc;  s2_valid = 1'b1;
                n_take   = 2'd2;
            end else if (is_alu(a_instr)) begin
                s1_instr = b_instr;  s1_pc = b_pc;  s1_valid = 1'b1;
                s2_instr = a_instr;  s2_pc = a_pc;  s2_valid = 1'b1;
                s_order  = 1'b1;
                n_take   = 2'd2;
            end else begin
                s1_instr = a_instr;  s1_pc = a_pc;  s1_valid = 1'b1;
                n_take   = 2'd1;
            end
        end else if (a_valid) begin
            s1_instr = a_instr;  s1_pc = a_pc;  s1_valid = 1'b1;
            n_take   = 2'd1;
        end
    end

    // In bypass the only lane that can still need a queue slot is lane 1.
    logic [31:0] w0_instr, w0_pc;
    logic [1:0]  n_push;
    logic [1:0]  n_pop;

    always_comb begin
        w0_instr = fetch_instr0;
        w0_pc    = fetch_pc0;
        n_push   = 2'd0;
        if (fetch_go && !flush_d) begin
            if (bypass) begin
                if (fetch_valid[1] && n_take == 2'd1) begin
                    w0_instr = fetch_instr1;
                    w0_pc    = fetch_pc1;
                    n_push   = 2'd1;
                end
            end else begin
                n_push = fetch_valid[1] ? 2'd2 : 2'd1;
            end
        end
        n_pop = (deq_en && !bypass) ? n_take : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem_instr[wr_ptr] <= w0_instr;
            mem_pc[wr_ptr]    <= w0_pc;
        end
        if (n_push == 2'd2) begin
            mem_instr[wr_ptr + PW'(1)] <= fetch_instr1;
            mem_pc[wr_ptr + PW'(1)]    <= fetch_pc1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            InstrD         <= NOP;
            PCD            <= '0;
            validD         <= 1'b0;
            InstrD_2       <= NOP;
            PCD_2          <= '0;
            validD_2       <= 1'b0;
            Order_Change_D <= 1'b0;
        end else if (flush_d) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            InstrD         <= NOP;
            PCD            <= '0;
            validD         <= 1'b0;
            InstrD_2       <= NOP;
            PCD_2          <= '0;
            validD_2       <= 1'b0;
            Order_Change_D <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(n_pop);
            count  <= count + CW'(n_push) - CW'(n_pop);
            if (!stall_d) begin
                InstrD         <= s1_instr;
                PCD            <= s1_pc;
                validD         <= s1_valid;
                InstrD_2       <= s2_instr;
                PCD_2          <= s2_pc;
                validD_2       <= s2_valid;
                Order_Change_D <= s_order;
            end
        end
    end

    assign rdd       = validD   ? InstrD[11:7]   : 5'd0;
    assign rdd_2     = validD_2 ? InstrD_2[11:7] : 5'd0;
    assign occupancy = count;

endmodule

// File: tb/tb_dual_issue_queue.sv
// Scoreboard bench for dual_issue_queue: a reference queue model predicts decode slots each cycle.
// Honours ISSUE_QUEUE_BYPASS_EN the same way the design does.
module tb_dual_issue_queue;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef ISSUE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1;
    logic        fetch_ready;
    logic        stall_d, flush_d;
    logic [31:0] InstrD, PCD, InstrD_2, PCD_2;
    logic        validD, validD_2, Order_Change_D;
    logic [4:0]  rdd, rdd_2;
    logic [$clog2(DEPTH):0] occupancy;

    dual_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid),
        .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
        .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
        .fetch_ready(fetch_ready),
        .stall_d(stall_d), .flush_d(flush_d),
        .InstrD(InstrD), .PCD(PCD), .validD(validD),
        .InstrD_2(InstrD_2), .PCD_2(PCD_2), .validD_2(validD_2),
        .Order_Change_D(Order_Change_D),
        .rdd(rdd), .rdd_2(rdd_2),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] i1, p1, i2, p2;
        logic        v1, v2, oc;
    } dec_t;

    ent_t mq[$];
    dec_t exp_q[$];
    dec_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_alu(input logic [31:0] instr);
        return instr[6:0] == 7'b0110011 || instr[6:0] == 7'b0010011 ||
               instr[6:0] == 7'b0110111 || instr[6:0] == 7'b0010111;
    endfunction

    function automatic dec_t nop_dec();
        dec_t d;
        d.i1 = NOP; d.p1 = '0; d.v1 = 1'b0;
        d.i2 = NOP; d.p2 = '0; d.v2 = 1'b0;
        d.oc = 1'b0;
        return d;
    endfunction

    function automatic dec_t steer(input ent_t s[$], output int n);
        dec_t d;
        d = nop_dec();
        n = 0;
        if (s.size() >= 2 && is_alu(s[1].instr)) begin
            d.i1 = s[0].instr; d.p1 = s[0].pc; d.v1 = 1'b1;
            d.i2 = s[1].instr; d.p2 = s[1].pc; d.v2 = 1'b1;
            n = 2;
        end else if (s.size() >= 2 && is_alu(s[0].instr)) begin
            d.i1 = s[1].instr; d.p1 = s[1].pc; d.v1 = 1'b1;
            d.i2 = s[0].instr; d.p2 = s[0].pc; d.v2 = 1'b1;
            d.oc = 1'b1;
            n = 2;
        end else if (s.size() >= 1) begin
            d.i1 = s[0].instr; d.p1 = s[0].pc; d.v1 = 1'b1;
            n = 1;
        end
        return d;
    endfunction

    task automatic compare_dec(input dec_t d);
        logic [31:0] e1, e2;
        e1 = d.v1 ? {27'd0, d.i1[11:7]} : 32'd0;
        e2 = d.v2 ? {27'd0, d.i2[11:7]} : 32'd0;
        chk("InstrD",         InstrD,                d.i1);
        chk("PCD",            PCD,                   d.p1);
        chk("validD",         32'(validD),           32'(d.v1));
        chk("InstrD_2",       InstrD_2,              d.i2);
        chk("PCD_2",          PCD_2,                 d.p2);
        chk("validD_2",       32'(validD_2),         32'(d.v2));
        chk("Order_Change_D", 32'(Order_Change_D),   32'(d.oc));
        chk("rdd",            32'(rdd),              e1);
        chk("rdd_2",          32'(rdd_2),            e2);
    endtask

    task automatic step(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic st, input logic fl);
        ent_t fetched[$];
        ent_t e;
        dec_t d;
        int   n;
        bit   rdy;
        @(negedge clk);
        fetch_valid  = fv;
        fetch_instr0 = i0;
        fetch_instr1 = i1;
        fetch_pc0    = pc_ctr;
        fetch_pc1    = pc_ctr + 32'd4;
        stall_d      = st;
        flush_d      = fl;
        rdy = (mq.size() <= DEPTH - 2);
        chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
        if (fl) begin
            mq.delete();
            cur = nop_dec();
        end else begin
            if (rdy && fv[0]) begin
                e.instr = i0; e.pc = pc_ctr; fetched.push_back(e);
                if (fv[1]) begin
                    e.instr = i1; e.pc = pc_ctr + 32'd4; fetched.push_back(e);
                end
                pc_ctr += fv[1] ? 32'd8 : 32'd4;
            end
            if (!st) begin
                if (BYP && mq.size() == 0) begin
                    d = steer(fetched, n);
                    repeat (n) void'(fetched.pop_front());
                end else begin
                    d = steer(mq, n);
                    repeat (n) void'(mq.pop_front());
                end
                cur = d;
            end
            foreach (fetched[k]) mq.push_back(fetched[k]);
        end
        exp_q.push_back(cur);
        @(posedge clk);
        #1;
        compare_dec(exp_q.pop_front());
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
    endtask

    task automatic idle(input logic st);
        step(2'b00, NOP, NOP, st, 1'b0);
    endtask

    function automatic logic [31:0] mk_instr(input int sel, input logic [4:0] rd);
        logic [6:0]  op;
        logic [19:0] hi;
        hi = 20'($urandom);
        case (sel % 8)
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0110111;
            3: op = 7'b0010111;
            4: op = 7'b0000011;
            5: op = 7'b0100011;
            6: op = 7'b1100011;
            default: op = 7'b1101111;
        endcase
        return {hi, rd, op};
    endfunction

    localparam logic [31:0] ADD_X1 = 32'h0000_00B3;
    localparam logic [31:0] LW_X2  = 32'h0000_0103;
    localparam logic [31:0] LW_X3  = 32'h0000_0183;
    localparam logic [31:0] SW_OP  = 32'h0000_2023;

    initial begin
        rst_n = 1'b0;
        fetch_valid = 2'b00;
        fetch_instr0 = NOP; fetch_instr1 = NOP;
        fetch_pc0 = '0; fetch_pc1 = '0;
        stall_d = 1'b0; flush_d = 1'b0;
        cur = nop_dec();
        #12;
        compare_dec(nop_dec());
        chk("occupancy_rst", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add x1 then lw x2: lw must issue in slot 1 with the add swapped to slot 2
        step(2'b11, ADD_X1, LW_X2, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // two non-ALU ops issue one per cycle
        step(2'b11, LW_X3, SW_OP, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        // fill while stalled, ready drops at DEPTH-1, extra push ignored
        for (int k = 0; k < 3; k++) step(2'b11, mk_instr(k, 5'(k + 1)), mk_instr(k + 4, 5'(k + 9)), 1'b1, 1'b0);
        step(2'b01, mk_instr(1, 5'd20), NOP, 1'b1, 1'b0);
        step(2'b11, mk_instr(0, 5'd21), mk_instr(0, 5'd22), 1'b1, 1'b0);
        step(2'b00, NOP, NOP, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(2'b11, mk_instr(k + 2, 5'(k + 3)), mk_instr(k, 5'(k + 12)), 1'b1, 1'b0);
        step(2'b11, mk_instr(0, 5'd30), mk_instr(1, 5'd31), 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) idle(1'b0);

        // five queued, then stall+flush with a same-cycle fetch
        step(2'b11, mk_instr(4, 5'd5), mk_instr(5, 5'd6), 1'b1, 1'b0);
        step(2'b11, mk_instr(0, 5'd7), mk_instr(6, 5'd8), 1'b1, 1'b0);
        step(2'b01, mk_instr(1, 5'd9), NOP, 1'b1, 1'b0);
        step(2'b11, mk_instr(0, 5'd10), mk_instr(1, 5'd11), 1'b1, 1'b1);
        idle(1'b0);

        // 20 ALU pairs with stall toggling each cycle; retry while full
        begin
            int pushed = 0;
            int cyc = 0;
            while (pushed < 20 && cyc < 200) begin
                if (mq.size() <= DEPTH - 2) begin
                    step(2'b11, mk_instr(pushed % 4, 5'(pushed)), mk_instr((pushed + 1) % 4, 5'(pushed + 1)),
                         1'(cyc % 2), 1'b0);
                    pushed++;
                end else begin
                    idle(1'(cyc % 2));
                end
                cyc++;
            end
            for (int k = 0; k < 12; k++) idle(1'b0);
        end

        // random mix of classes, stalls and occasional flushes
        for (int k = 0; k < 300; k++) begin
            logic [1:0] fv;
            int r;
            r = int'($urandom_range(0, 2));
            fv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            step(fv, mk_instr(int'($urandom_range(0, 7)), 5'($urandom)),
                 mk_instr(int'($urandom_range(0, 7)), 5'($urandom)),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
        end

        // asynchronous reset in the middle of traffic
        step(2'b11, mk_instr(4, 5'd1), mk_instr(5, 5'd2), 1'b1, 1'b0);
        step(2'b11, mk_instr(0, 5'd3), mk_instr(1, 5'd4), 1'b0, 1'b0);
        @(negedge clk);
        fetch_valid = 2'b00;
        stall_d = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        compare_dec(nop_dec());
        chk("occupancy_async_rst", 32'(occupancy), 32'd0);
        chk("fetch_ready_async_rst", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        cur = nop_dec();
        idle(1'b0);
        step(2'b01, LW_X2, NOP, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
